prim_ram_1p_bist: RTL and testbench



---
 rtl/prim_ram_1p_bist.sv | 200 ++++++++++++++++++++
 tb/tb_prim_ram_1p_bist.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prim_ram_1p_bist.sv
// March-style BIST initiator for a single-port RAM request interface.
// Sequence: W0 (write P ascending), R0W1 (read P / write ~P ascending),
// R1 (read ~P descending), DRAIN (last compare), DONE (report).
module prim_ram_1p_bist #(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 128,
    parameter int unsigned ErrCntW = 16,
    localparam int unsigned Aw     = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [Width-1:0]   pattern_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [ErrCntW-1:0] err_cnt_o,
    output logic [Aw-1:0]      first_err_addr_o,
    output logic [Width-1:0]   first_err_mask_o,
    output logic               ram_req_o,
    output logic               ram_write_o,
    output logic [Aw-1:0]      ram_addr_o,
    output logic [Width-1:0]   ram_wdata_o,
    output logic [Width-1:0]   ram_wmask_o,
    input  logic [Width-1:0]   ram_rdata_i
);

    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    typedef enum logic [2:0] {
        StIdle,
        StW0,
        StR0W1,
        StR1,
        StDrain,
        StDone
    } state_e;

    state_e             state_q;
    logic               phase_q;    // R0W1: 0 = read cycle, 1 = write-back cycle
    logic [Width-1:0]   pattern_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               req_q;
    logic               write_q;
    logic [Aw-1:0]      addr_q;
    logic [Width-1:0]   wdata_q;
    logic [Width-1:0]   wmask_q;

    // Pending-compare pipeline: one entry per read, checked the cycle after.
    logic               cmp_valid_q;
    logic [Aw-1:0]      cmp_addr_q;
    logic [Width-1:0]   cmp_exp_q;
    logic [ErrCntW-1:0] err_cnt_q;
    logic [ErrCntW-1:0] err_cnt_d;
    logic [Aw-1:0]      first_addr_q;
    logic [Width-1:0]   first_mask_q;
    logic               mismatch;
    logic               start_test;

    assign start_test = (state_q == StIdle) && start_i;

    // Word mismatch detection and saturating error count.
    always_comb begin
        mismatch  = cmp_valid_q && (ram_rdata_i != cmp_exp_q);
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != {ErrCntW{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Test sequencer with registered RAM request and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            phase_q   <= 1'b0;
            pattern_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            req_q     <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StW0;
                        pattern_q <= pattern_i;
                        busy_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        req_q     <= 1'b1;
                        write_q   <= 1'b1;
                        addr_q    <= '0;
                        wdata_q   <= pattern_i;
                        wmask_q   <= '1;
                    end
                end
                StW0: begin
                    if (addr_q == LastAddr) begin
                        state_q <= StR0W1;
                        phase_q <= 1'b0;
                        write_q <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                StR0W1: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                        write_q <= 1'b1;
                        wdata_q <= ~pattern_q;
                        wmask_q <= '1;
                    end else begin
                        phase_q <= 1'b0;
                        write_q <= 1'b0;
                        wdata_q <= '0;
                        wmask_q <= '0;
                        if (addr_q == LastAddr) begin
                            state_q <= StR1;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                StR1: begin
                    if (addr_q == '0) begin
                        state_q <= StDrain;
                        req_q   <= 1'b0;
                    end else begin
                        addr_q <= addr_q - 1'b1;
                    end
                end
                StDrain: begin
                    // The final read of address 0 is compared this cycle.
                    state_q <= StDone;
                    done_q  <= 1'b1;
                    pass_q  <= (err_cnt_d == '0);
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Compare pipeline registers and first-error capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= '0;
            cmp_exp_q    <= '0;
            err_cnt_q    <= '0;
            first_addr_q <= '0;
            first_mask_q <= '0;
        end else begin
            cmp_valid_q <= req_q && !write_q;
            cmp_addr_q  <= addr_q;
            cmp_exp_q   <= (state_q == StR1) ? ~pattern_q : pattern_q;
            if (start_test) begin
                err_cnt_q    <= '0;
                first_addr_q <= '0;
                first_mask_q <= '0;
            end else begin
                err_cnt_q <= err_cnt_d;
                // Counter saturates, never wraps, so zero means no prior mismatch.
                if (mismatch && (err_cnt_q == '0)) begin
                    first_addr_q <= cmp_addr_q;
                    first_mask_q <= ram_rdata_i ^ cmp_exp_q;
                end
            end
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_addr_q;
    assign first_err_mask_o = first_mask_q;
    assign ram_req_o        = req_q;
    assign ram_write_o      = write_q;
    assign ram_addr_o       = addr_q;
    assign ram_wdata_o      = wdata_q;
    assign ram_wmask_o      = wmask_q;

endmodule

// File: tb/tb_prim_ram_1p_bist.sv
// Bench for prim_ram_1p_bist: bad-bit RAM models, request/result scoreboard.
module tb_prim_ram_1p_bist;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  pattern = '0;

    logic          busy, done, pass;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_addr;
    logic [W-1:0]  first_mask;
    logic          ram_req, ram_write;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata, ram_wmask, ram_rdata;

    logic          busy2, done2, pass2;
    logic [3:0]    err_cnt2;
    logic [AW-1:0] first_addr2;
    logic [W-1:0]  first_mask2;
    logic          ram_req2, ram_write2;
    logic [AW-1:0] ram_addr2;
    logic [W-1:0]  ram_wdata2, ram_wmask2, ram_rdata2;

    // Bad-bit injection controls for the main RAM model.
    logic [W-1:0]  bad_mask = '0;
    logic          bad_all = 1'b0;
    logic [AW-1:0] bad_addr = '0;

    logic [W-1:0]  mem [D];
    logic [W-1:0]  mem2 [D];

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int cyc = 0;
    int t_first = 0;
    bit in_test = 1'b0;

    logic [127:0] txq [$];
    logic [127:0] resq [$];

    always #5 clk = ~clk;

    prim_ram_1p_bist #(.Width(W), .Depth(D), .ErrCntW(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pattern_i(pattern),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
        .first_err_addr_o(first_addr), .first_err_mask_o(first_mask),
        .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata)
    );

    // Second instance with a narrow counter; its RAM corrupts every read.
    prim_ram_1p_bist #(.Width(W), .Depth(D), .ErrCntW(4)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pattern_i(pattern),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_cnt_o(err_cnt2),
        .first_err_addr_o(first_addr2), .first_err_mask_o(first_mask2),
        .ram_req_o(ram_req2), .ram_write_o(ram_write2), .ram_addr_o(ram_addr2),
        .ram_wdata_o(ram_wdata2), .ram_wmask_o(ram_wmask2), .ram_rdata_i(ram_rdata2)
    );

    // Registered RAM models: read data valid the cycle after a read request.
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_write) begin
                mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            end else begin
                ram_rdata <= mem[ram_addr] ^
                             ((bad_all || ram_addr == bad_addr) ? bad_mask : '0);
            end
        end
        if (ram_req2) begin
            if (ram_write2) begin
                mem2[ram_addr2] <= (mem2[ram_addr2] & ~ram_wmask2) |
                                   (ram_wdata2 & ram_wmask2);
            end else begin
                ram_rdata2 <= mem2[ram_addr2] ^ 32'h0000_0001;
            end
        end
    end

    task automatic check_val(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected request stream of one full march, in issue order.
    task automatic push_expected(input logic [W-1:0] p, input logic exp_pass,
                                 input logic [15:0] exp_cnt, input logic [AW-1:0] exp_addr,
                                 input logic [W-1:0] exp_mask);
        for (int i = 0; i < D; i++) txq.push_back({1'b1, 1'b1, AW'(i), p, 32'hFFFF_FFFF});
        for (int i = 0; i < D; i++) begin
            txq.push_back({1'b1, 1'b0, AW'(i), 32'h0, 32'h0});
            txq.push_back({1'b1, 1'b1, AW'(i), ~p, 32'hFFFF_FFFF});
        end
        for (int i = D - 1; i >= 0; i--) txq.push_back({1'b1, 1'b0, AW'(i), 32'h0, 32'h0});
        resq.push_back({exp_pass, exp_cnt, exp_addr, exp_mask});
    endtask

    task automatic pulse_start(input logic [W-1:0] p);
        @(negedge clk);
        start = 1'b1;
        pattern = p;
        @(negedge clk);
        start = 1'b0;
        pattern = ~p;
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_val("done_timeout", done_cnt != d0, 1);
        repeat (4) @(negedge clk);
        check_val("one_done", done_cnt - d0, 1);
        check_val("tx_drained", txq.size(), 0);
    endtask

    task automatic run_test(input logic [W-1:0] p, input logic [W-1:0] m, input logic all,
                            input logic [AW-1:0] ba, input logic exp_pass,
                            input logic [15:0] exp_cnt, input logic [AW-1:0] exp_addr,
                            input logic [W-1:0] exp_mask, input logic mid_start);
        int d0 = done_cnt;
        bad_mask = m;
        bad_all = all;
        bad_addr = ba;
        push_expected(p, exp_pass, exp_cnt, exp_addr, exp_mask);
        pulse_start(p);
        if (mid_start) begin
            repeat (24) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(d0);
    endtask

    // Monitor: pop expected requests and results as the DUT produces them.
    always @(negedge clk) begin
        logic [127:0] obs;
        cyc++;
        if (!rst_n) begin
            in_test = 1'b0;
        end else begin
            if (ram_req) begin
                if (!in_test) begin
                    in_test = 1'b1;
                    t_first = cyc;
                end
                obs = {1'b1, ram_write, ram_addr, ram_write ? ram_wdata : 32'h0, ram_wmask};
                check_val("tx_pending", txq.size() != 0, 1);
                if (txq.size() != 0) check_val("ram_req", obs, txq.pop_front());
            end
            if (done) begin
                done_cnt++;
                in_test = 1'b0;
                check_val("done_latency", cyc - t_first, 4 * D + 1);
                check_val("busy_at_done", busy, 1);
                check_val("res_pending", resq.size() != 0, 1);
                if (resq.size() != 0) begin
                    check_val("result", {pass, err_cnt, first_addr, first_mask},
                              resq.pop_front());
                end
                check_val("sat_done", done2, 1);
                check_val("sat_cnt", err_cnt2, 15);
                check_val("sat_pass", pass2, 0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_outputs", {busy, done, pass, err_cnt, first_addr, first_mask}, 0);
        check_val("rst_ram", {ram_req, ram_write, ram_addr, ram_wdata, ram_wmask}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_busy", busy, 0);

        // Clean RAM.
        run_test(32'hA5A5_A5A5, 32'h0, 1'b0, 4'd0, 1'b1, 16'd0, 4'd0, 32'h0, 1'b0);
        check_val("results_hold", {pass, err_cnt}, {1'b1, 16'd0});
        // Constant bad bit on every read: all 2*D reads fail.
        run_test(32'h0F0F_1234, 32'h8, 1'b1, 4'd0, 1'b0, 16'd32, 4'd0, 32'h8, 1'b0);
        // Bad bits only on address 5: one R0W1 and one R1 failure.
        run_test(32'h1357_9BDF, 32'h8000_0001, 1'b0, 4'd5, 1'b0, 16'd2, 4'd5,
                 32'h8000_0001, 1'b0);
        // Start pulsed mid-R0W1 must be ignored.
        run_test(32'hDEAD_BEEF, 32'h0, 1'b0, 4'd0, 1'b1, 16'd0, 4'd0, 32'h0, 1'b1);

        // Reset during R0W1 aborts immediately.
        push_expected(32'h3C3C_C3C3, 1'b1, 16'd0, 4'd0, 32'h0);
        pulse_start(32'h3C3C_C3C3);
        repeat (24) @(negedge clk);
        check_val("busy_mid", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_ram", {ram_req, ram_write, ram_addr, ram_wdata, ram_wmask}, 0);
        check_val("abort_outputs", {busy, done, pass, err_cnt, first_addr, first_mask}, 0);
        txq.delete();
        resq.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_test(32'h6666_9999, 32'h0, 1'b0, 4'd0, 1'b1, 16'd0, 4'd0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
